alu_nbit_reg: RTL and testbench
===============================

Name: alu_nbit_reg

Overview:
- Parameterised N-bit, 4-operation ALU: ADD, SUB, AND, OR, with carry/borrow in and out.
- Built as a ripple of identical 1-bit slices; registered output stage with a valid flag.
- Serves as a generic datapath arithmetic/logic element; WIDTH=1 and WIDTH=4 are the baseline configurations.

Parameters:
- WIDTH, 4, operand/result width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operands/opcode/cin valid this cycle
- a  input  WIDTH  operand A (unsigned)
- b  input  WIDTH  operand B (unsigned)
- opcode  input  2  00=ADD, 01=SUB, 10=AND, 11=OR
- cin  input  1  carry-in (ADD) / borrow-in (SUB); ignored for AND/OR
- result  output  WIDTH  registered result
- cout  output  1  registered carry-out (ADD) / borrow-out (SUB); 0 for AND/OR
- out_valid  output  1  result/cout updated from a valid request
- zero  output  1  (ALU_FLAGS_EN only) result==0
- ovf  output  1  (ALU_FLAGS_EN only) signed overflow

Behaviour:
- Reset: on rising clk with rst=1 -> result=0, cout=0, out_valid=0 (and zero=1, ovf=0 when flags are compiled in). rst has priority over in_valid.
- Latency: exactly 1 cycle. Inputs sampled at edge k with in_valid=1 appear on result/cout at edge k, visible during cycle k+1, with out_valid=1.
- in_valid=0 at an edge: result/cout hold their previous values; out_valid=0. No backpressure; a new request is accepted every cycle.
- ADD: {cout,result} = a + b + cin, computed at WIDTH+1 bits. Example: 1001+0111+0 -> result 0000, cout 1.
- SUB: result = (a - b - cin) mod 2^WIDTH. cout = borrow = 1 iff a < b + cin (unsigned). Example: 1111-0000-0 -> 1111, cout 0.
- AND: result = a & b, bitwise; cout=0.
- OR: result = a | b, bitwise; cout=0.
- Ripple structure: slice i receives the carry/borrow from slice i-1; slice 0 receives cin; the last slice's carry/borrow out is cout.
- WIDTH=1 is a single slice and must satisfy the same rules.
- Wrap-around: ADD/SUB results are modulo 2^WIDTH; overflow is reported only via cout (and ovf if enabled).
- Unknown or X inputs are not handled specially.

Optional Feature:
- Macro ALU_FLAGS_EN.
- Defined: adds ports zero and ovf, registered alongside result with the same reset and hold rules.
  - zero = (next result == 0) for all ops.
  - ovf = signed two's-complement overflow for ADD/SUB (carry into MSB xor carry out of MSB); 0 for AND/OR.
- Undefined: ports zero and ovf are absent; no flag logic is present.

Decomposition:
- Shared package alu_pkg:
  - opcode typedef/localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11
  - reset value constants.
- One sub-module alu_bit_slice, combinational, one per bit via generate:
  - inputs: a, b, opcode, carry_in
  - outputs: res, carry_out
  - SUB: res = a^b^bin; bout = (~a&b) | (~(a^b)&bin).
- Top level holds only the slice chain, output registers and optional flags.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1, a=1111, b=1111 -> result=0000, cout=0, out_valid=0; deassert -> next edge produces a real result.
- ADD, WIDTH=4:
  - 1001+0110, cin=0 -> 1111, cout 0
  - 1001+0111, cin=0 -> 0000, cout 1
  - 1111+0000, cin=1 -> 0000, cout 1
- ADD/SUB, WIDTH=1:
  - 1+0, cin=0 -> 1, cout 0
  - 1+1, cin=0 -> 0, cout 1
  - SUB 1-0, cin=0 -> 1, cout 0
  - SUB 0-1, cin=0 -> 1, cout 1
- SUB, WIDTH=4:
  - 1111-0000, cin=0 -> 1111, cout 0
  - 0000-0001, cin=0 -> 1111, cout 1
  - 0101-0101, cin=1 -> 1111, cout 1
- Logic, WIDTH=4:
  - AND 1010&0101 -> 0000; AND 1010&1111 -> 1010; AND 1111&1111 -> 1111
  - OR 1010|0101 -> 1111; OR 1010|0000 -> 1010
  - cout=0 for all, including cin=1
- Hold/valid: a valid request, then in_valid=0 with changed operands for 3 cycles -> result/cout unchanged, out_valid=0; back-to-back valid requests update every cycle. With ALU_FLAGS_EN, ADD 0111+0001 -> ovf=1, zero=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encoding and reset constants for the N-bit ripple ALU.
package alu_pkg;

  localparam int unsigned OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;

  localparam logic RST_COUT  = 1'b0;
  localparam logic RST_VALID = 1'b0;
  localparam logic RST_ZERO  = 1'b1;
  localparam logic RST_OVF   = 1'b0;

endpackage

// File: rtl/alu_bit_slice.sv
// One bit of the ALU: sum/difference/logic result plus carry or borrow toward the next bit.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic    a,
  input  logic    b,
  input  alu_op_e opcode,
  input  logic    carry_in,
  output logic    res,
  output logic    carry_out
);

  // Logic ops force the chain to 0 so the final carry reads 0 for AND/OR.
  always_comb begin
    res       = 1'b0;
    carry_out = 1'b0;
    case (opcode)
      OP_ADD: begin
        res       = a ^ b ^ carry_in;
        carry_out = (a & b) | ((a ^ b) & carry_in);
      end
      OP_SUB: begin
        res       = a ^ b ^ carry_in;
        carry_out = (~a & b) | (~(a ^ b) & carry_in);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      default: begin
        res       = 1'b0;
        carry_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_nbit_reg.sv
// Ripple-chain N-bit ADD/SUB/AND/OR ALU with one registered output stage.
// Define ALU_FLAGS_EN to add registered zero and signed-overflow flags.
module alu_nbit_reg
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       opcode,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             out_valid
`ifdef ALU_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("alu_nbit_reg: WIDTH must be in 1..32");
    end
  endgenerate

  alu_op_e          op;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] res_c;

  assign op       = alu_op_e'(opcode);
  assign carry[0] = cin;

  // Slice i consumes carry[i] and produces carry[i+1]; carry[WIDTH] is the final carry/borrow.
  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    alu_bit_slice u_slice (
      .a         (a[i]),
      .b         (b[i]),
      .opcode    (op),
      .carry_in  (carry[i]),
      .res       (res_c[i]),
      .carry_out (carry[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      cout      <= RST_COUT;
      out_valid <= RST_VALID;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result <= res_c;
        cout   <= carry[WIDTH];
      end
    end
  end

`ifdef ALU_FLAGS_EN
  logic zero_c;
  logic ovf_c;

  // Borrow-in xor borrow-out at the MSB equals carry-in xor carry-out, so one rule covers ADD and SUB.
  always_comb begin
    zero_c = (res_c == '0);
    ovf_c  = 1'b0;
    if (op == OP_ADD || op == OP_SUB) begin
      ovf_c = carry[WIDTH-1] ^ carry[WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero <= RST_ZERO;
      ovf  <= RST_OVF;
    end else if (in_valid) begin
      zero <= zero_c;
      ovf  <= ovf_c;
    end
  end
`endif

endmodule

// File: tb/tb_alu_nbit_reg.sv
// Directed self-checking bench for alu_nbit_reg at WIDTH=4 and WIDTH=1 (flags checked when ALU_FLAGS_EN is defined).
`timescale 1ns/1ps
module tb_alu_nbit_reg;

  logic       clk = 1'b0;
  logic       rst;

  logic       v4, c4, ov4, co4;
  logic [3:0] a4, b4, r4;
  logic [1:0] op4;
  logic       v1, c1, ov1, co1;
  logic [0:0] a1, b1, r1;
  logic [1:0] op1;
`ifdef ALU_FLAGS_EN
  logic       z4, f4, z1, f1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_nbit_reg #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .opcode(op4), .cin(c4),
    .result(r4), .cout(co4), .out_valid(ov4)
`ifdef ALU_FLAGS_EN
    , .zero(z4), .ovf(f4)
`endif
  );

  alu_nbit_reg #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .opcode(op1), .cin(c1),
    .result(r1), .cout(co1), .out_valid(ov1)
`ifdef ALU_FLAGS_EN
    , .zero(z1), .ovf(f1)
`endif
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check4(input string tag, input logic [3:0] er, input logic ec,
                        input logic ev, input logic eo);
    chk({tag, ".result"}, r4, er);
    chk({tag, ".cout"}, 4'(co4), 4'(ec));
    chk({tag, ".valid"}, 4'(ov4), 4'(ev));
`ifdef ALU_FLAGS_EN
    chk({tag, ".zero"}, 4'(z4), 4'(er == 4'b0000));
    chk({tag, ".ovf"}, 4'(f4), 4'(eo));
`else
    if (eo === 1'bx) $error("FAIL %s: bad ovf expectation", tag);
`endif
  endtask

  task automatic check1(input string tag, input logic er, input logic ec,
                        input logic ev, input logic eo);
    chk({tag, ".result"}, 4'(r1), 4'(er));
    chk({tag, ".cout"}, 4'(co1), 4'(ec));
    chk({tag, ".valid"}, 4'(ov1), 4'(ev));
`ifdef ALU_FLAGS_EN
    chk({tag, ".zero"}, 4'(z1), 4'(er == 1'b0));
    chk({tag, ".ovf"}, 4'(f1), 4'(eo));
`else
    if (eo === 1'bx) $error("FAIL %s: bad ovf expectation", tag);
`endif
  endtask

  task automatic run4(input string tag, input logic [1:0] op, input logic [3:0] a,
                      input logic [3:0] b, input logic cin,
                      input logic [3:0] er, input logic ec, input logic eo);
    v4 = 1'b1; op4 = op; a4 = a; b4 = b; c4 = cin;
    tick();
    check4(tag, er, ec, 1'b1, eo);
  endtask

  task automatic run1(input string tag, input logic [1:0] op, input logic a,
                      input logic b, input logic cin,
                      input logic er, input logic ec, input logic eo);
    v1 = 1'b1; op1 = op; a1 = a; b1 = b; c1 = cin;
    tick();
    check1(tag, er, ec, 1'b1, eo);
  endtask

  initial begin
    // Reset with a live request present: reset must win.
    rst = 1'b1;
    v4 = 1'b1; op4 = 2'b00; a4 = 4'b1111; b4 = 4'b1111; c4 = 1'b0;
    v1 = 1'b1; op1 = 2'b00; a1 = 1'b1;    b1 = 1'b1;    c1 = 1'b0;
    tick();
    tick();
    chk("rst4.result", r4, 4'b0000);
    chk("rst4.cout", 4'(co4), 4'b0);
    chk("rst4.valid", 4'(ov4), 4'b0);
    chk("rst1.result", 4'(r1), 4'b0);
    chk("rst1.cout", 4'(co1), 4'b0);
    chk("rst1.valid", 4'(ov1), 4'b0);
`ifdef ALU_FLAGS_EN
    chk("rst4.zero", 4'(z4), 4'b1);
    chk("rst4.ovf", 4'(f4), 4'b0);
    chk("rst1.zero", 4'(z1), 4'b1);
    chk("rst1.ovf", 4'(f1), 4'b0);
`endif

    // First edge after release computes 1111+1111 and 1+1.
    rst = 1'b0;
    tick();
    check4("rel4", 4'b1110, 1'b1, 1'b1, 1'b0);
    check1("rel1", 1'b0, 1'b1, 1'b1, 1'b1);
    v1 = 1'b0;

    // ADD, WIDTH=4
    run4("add_a", 2'b00, 4'b1001, 4'b0110, 1'b0, 4'b1111, 1'b0, 1'b0);
    run4("add_b", 2'b00, 4'b1001, 4'b0111, 1'b0, 4'b0000, 1'b1, 1'b0);
    run4("add_c", 2'b00, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0);
    run4("add_ovf", 2'b00, 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1);

    // SUB, WIDTH=4
    run4("sub_a", 2'b01, 4'b1111, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b0);
    run4("sub_b", 2'b01, 4'b0000, 4'b0001, 1'b0, 4'b1111, 1'b1, 1'b0);
    run4("sub_c", 2'b01, 4'b0101, 4'b0101, 1'b1, 4'b1111, 1'b1, 1'b0);
    run4("sub_ovf", 2'b01, 4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1);

    // Logic ops, cin must not leak into cout
    run4("and_a", 2'b10, 4'b1010, 4'b0101, 1'b1, 4'b0000, 1'b0, 1'b0);
    run4("and_b", 2'b10, 4'b1010, 4'b1111, 1'b0, 4'b1010, 1'b0, 1'b0);
    run4("and_c", 2'b10, 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b0, 1'b0);
    run4("or_a", 2'b11, 4'b1010, 4'b0101, 1'b1, 4'b1111, 1'b0, 1'b0);
    run4("or_b", 2'b11, 4'b1010, 4'b0000, 1'b0, 4'b1010, 1'b0, 1'b0);

    // Hold: one valid request, then three idle cycles with changed operands
    run4("hold_req", 2'b00, 4'b0011, 4'b0001, 1'b0, 4'b0100, 1'b0, 1'b0);
    v4 = 1'b0;
    op4 = 2'b01; a4 = 4'b0000; b4 = 4'b1111; c4 = 1'b1;
    tick();
    check4("hold_1", 4'b0100, 1'b0, 1'b0, 1'b0);
    a4 = 4'b1111; b4 = 4'b1111; op4 = 2'b00;
    tick();
    check4("hold_2", 4'b0100, 1'b0, 1'b0, 1'b0);
    op4 = 2'b11; a4 = 4'b1010;
    tick();
    check4("hold_3", 4'b0100, 1'b0, 1'b0, 1'b0);

    // Back-to-back valid requests, ending with an overflowing ADD
    run4("b2b_1", 2'b01, 4'b0110, 4'b0010, 1'b0, 4'b0100, 1'b0, 1'b0);
    run4("b2b_2", 2'b00, 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1);
    v4 = 1'b0;

    // WIDTH=1 single slice
    run1("w1_add_a", 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run1("w1_add_b", 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    run1("w1_sub_a", 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run1("w1_sub_b", 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    run1("w1_and", 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    v1 = 1'b0;
    a1 = 1'b0;
    tick();
    check1("w1_hold", 1'b1, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
